mvu_job_dispatcher: RTL
=======================

Name: mvu_job_dispatcher

Overview:
- MVU-side endpoint of the per-hart CSR/MVU interface.
- Accepts per-hart mvu_start pulses and the packed per-hart MVU configuration vectors from the barrel CSR file bank.
- Arbitrates round-robin among harts with pending jobs and snapshots the winner's configuration.
- Launches one job at a time on the single MVU, waits for completion or timeout, then returns a one-cycle mvu_irq to the originating hart.

Parameters:
- NUM_HARTS, 8, number of barrel harts / CSR files.
- HART_CNT_WIDTH, pito_pkg::HART_CNT_WIDTH, width of a hart index.
- TIMEOUT_CYCLES, 65535, maximum BUSY cycles before forced completion with error; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- mvu_start  in  NUM_HARTS  per-hart job request pulse from the CSR files.
- csr_mvu_wbaseaddr  in  32*NUM_HARTS  per-hart weight base, hart h at [h*32+:32].
- csr_mvu_ibaseaddr  in  32*NUM_HARTS  per-hart input base.
- csr_mvu_obaseaddr  in  32*NUM_HARTS  per-hart output base.
- csr_mvu_precision  in  32*NUM_HARTS  per-hart precision.
- csr_mvu_command  in  32*NUM_HARTS  per-hart command.
- csr_mvu_quant  in  32*NUM_HARTS  per-hart quant.
- mvu_done_i  in  1  MVU job complete pulse.
- mvu_irq  out  NUM_HARTS  one-hot completion interrupt to the CSR files.
- mvu_start_o  out  1  single-cycle MVU launch.
- mvu_busy_o  out  1  high from LAUNCH through IRQ inclusive.
- active_hart_o  out  HART_CNT_WIDTH  hart owning the current or last job.
- mvu_err_o  out  1  pulses with mvu_irq when a job ended by timeout.
- mvu_wbaseaddr_o, mvu_ibaseaddr_o, mvu_obaseaddr_o, mvu_precision_o, mvu_command_o, mvu_quant_o  out  32 each  snapshotted configuration.

Behaviour:
- Reset: all outputs are 0. pending is cleared, the FSM is in IDLE, the timeout counter is 0, and last_grant = NUM_HARTS-1 so hart 0 has first priority.
- pending[h] is set at the clock edge where mvu_start[h]=1.
  - A start for an already-pending hart is absorbed; there is no second queue entry.
  - A start for the currently active hart sets pending, so a new job is queued.
  - If a set and a grant-clear hit the same bit in the same cycle, the set wins.
- FSM states are IDLE, LAUNCH, BUSY, IRQ.
- IDLE: if pending is nonzero, the winner is the first set bit searching upward from last_grant+1, with wrap-around. On that edge:
  - clear pending[winner];
  - set last_grant and active_hart_o to the winner;
  - latch all six config fields for the winner into the *_o registers;
  - go to LAUNCH.
- LAUNCH: mvu_start_o=1 for exactly this cycle. The counter is cleared. Go to BUSY.
- BUSY:
  - mvu_done_i=1 goes to IRQ with err=0.
  - Otherwise, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1, go to IRQ with err=1.
  - Otherwise increment the counter.
  - If done and timeout fire in the same cycle, done wins.
- IRQ: mvu_irq[active_hart_o]=1 and mvu_err_o=err for exactly this cycle. Go to IDLE.
- mvu_done_i outside BUSY is ignored.
- Latency:
  - mvu_start[h] in cycle t with IDLE and no other pending: mvu_start_o is high in cycle t+2.
  - mvu_done_i in cycle d: mvu_irq[h] is high in cycle d+1.
  - IRQ to next LAUNCH takes a minimum of 2 cycles.
- Snapshot outputs and active_hart_o hold their values until the next grant. CSR rewrites after the grant edge do not affect the running job.
- Asserting rst_n low at any point, including mid-BUSY, aborts immediately: no irq is issued and pending jobs are lost.
- The counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.

Decomposition:
- In pito_pkg:
  - mvu_disp_state_t enum {IDLE, LAUNCH, BUSY, IRQ};
  - MVU_DISP_TIMEOUT default constant.
- Sub-module mvu_rr_arbiter: combinational round-robin pick.
  - Inputs: req[NUM_HARTS], last_grant.
  - Outputs: valid, grant_idx.
- The dispatcher holds the pending register, FSM, counter, snapshot registers and config muxes.

Test Plan:
- Single job: hart 3 has wbaseaddr=0x100 and command=0x5, mvu_start[3] at cycle 0. Expect mvu_start_o in cycle 2, active_hart_o=3, mvu_wbaseaddr_o=0x100, mvu_command_o=0x5. mvu_done_i at cycle 10 gives mvu_irq=8'b0000_1000 in cycle 11 with mvu_err_o=0.
- Fairness: mvu_start to harts 0, 5 and 7 in the same cycle, each done 4 cycles after launch, gives launch order 0, 5, 7. Then starts to harts 0 and 1 together give order 0, 1 (last_grant=7 wraps).
- Snapshot isolation: after hart 2's launch, change its csr_mvu_wbaseaddr from 0x40 to 0x80. mvu_wbaseaddr_o stays 0x40 until done and irq.
- Timeout: with TIMEOUT_CYCLES=16 and launch in cycle L and no done, mvu_irq[h] and mvu_err_o are high in cycle L+17. A later done pulse is ignored.
- Requeue: mvu_start[4] while hart 4 is BUSY, plus a duplicate start for the same hart. Exactly one extra job launches, 2 cycles after the first irq.
- Reset mid-BUSY: rst_n low for 2 cycles gives all outputs 0 and pending empty. A subsequent mvu_start[6] dispatches with normal t+2 latency.

Source files
------------

// File: rtl/pito_pkg.sv
// Shared definitions for the pito barrel core and its MVU job dispatcher.
//   NUM_HARTS        : default number of barrel harts / CSR files
//   HART_CNT_WIDTH   : width of a hart index
//   MVU_DISP_TIMEOUT : default BUSY cycle limit before a forced completion
//   mvu_disp_state_t : dispatcher FSM states
package pito_pkg;

  localparam int NUM_HARTS        = 8;
  localparam int HART_CNT_WIDTH   = $clog2(NUM_HARTS);
  localparam int MVU_DISP_TIMEOUT = 65535;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY,
    IRQ
  } mvu_disp_state_t;

endpackage

// File: rtl/mvu_job_dispatcher_if.sv
// Bundle between the CSR file bank / MVU and the job dispatcher.
//   slave  : dispatcher side (takes per-hart starts, packed CSR config and
//            the MVU done pulse; drives irqs, MVU launch and the snapshot)
//   master : CSR bank / MVU side (the opposite directions)
// Packed per-hart fields place hart h at bits [h*32 +: 32].
interface mvu_job_dispatcher_if
  import pito_pkg::*;
#(
  parameter int NUM_HARTS      = 8,
  parameter int HART_CNT_WIDTH = pito_pkg::HART_CNT_WIDTH
);

  logic [NUM_HARTS-1:0]      mvu_start;
  logic [32*NUM_HARTS-1:0]   csr_mvu_wbaseaddr;
  logic [32*NUM_HARTS-1:0]   csr_mvu_ibaseaddr;
  logic [32*NUM_HARTS-1:0]   csr_mvu_obaseaddr;
  logic [32*NUM_HARTS-1:0]   csr_mvu_precision;
  logic [32*NUM_HARTS-1:0]   csr_mvu_command;
  logic [32*NUM_HARTS-1:0]   csr_mvu_quant;
  logic                      mvu_done_i;

  logic [NUM_HARTS-1:0]      mvu_irq;
  logic                      mvu_start_o;
  logic                      mvu_busy_o;
  logic [HART_CNT_WIDTH-1:0] active_hart_o;
  logic                      mvu_err_o;
  logic [31:0]               mvu_wbaseaddr_o;
  logic [31:0]               mvu_ibaseaddr_o;
  logic [31:0]               mvu_obaseaddr_o;
  logic [31:0]               mvu_precision_o;
  logic [31:0]               mvu_command_o;
  logic [31:0]               mvu_quant_o;

  modport slave (
    input  mvu_start, csr_mvu_wbaseaddr, csr_mvu_ibaseaddr, csr_mvu_obaseaddr,
           csr_mvu_precision, csr_mvu_command, csr_mvu_quant, mvu_done_i,
    output mvu_irq, mvu_start_o, mvu_busy_o, active_hart_o, mvu_err_o,
           mvu_wbaseaddr_o, mvu_ibaseaddr_o, mvu_obaseaddr_o,
           mvu_precision_o, mvu_command_o, mvu_quant_o
  );

  modport master (
    output mvu_start, csr_mvu_wbaseaddr, csr_mvu_ibaseaddr, csr_mvu_obaseaddr,
           csr_mvu_precision, csr_mvu_command, csr_mvu_quant, mvu_done_i,
    input  mvu_irq, mvu_start_o, mvu_busy_o, active_hart_o, mvu_err_o,
           mvu_wbaseaddr_o, mvu_ibaseaddr_o, mvu_obaseaddr_o,
           mvu_precision_o, mvu_command_o, mvu_quant_o
  );

endinterface

// File: rtl/mvu_rr_arbiter.sv
// Combinational round-robin pick among requesting harts.
//   req        : per-hart request vector
//   last_grant : most recent winner; search starts at last_grant+1
//   valid      : any request present
//   grant_idx  : first requesting hart at or after last_grant+1 (wrapping)
module mvu_rr_arbiter
  import pito_pkg::*;
#(
  parameter int NUM_HARTS      = 8,
  parameter int HART_CNT_WIDTH = pito_pkg::HART_CNT_WIDTH
) (
  input  logic [NUM_HARTS-1:0]      req,
  input  logic [HART_CNT_WIDTH-1:0] last_grant,
  output logic                      valid,
  output logic [HART_CNT_WIDTH-1:0] grant_idx
);

  logic [2*NUM_HARTS-1:0] req_dbl;
  logic [NUM_HARTS-1:0]   req_rot;
  int                     offset;
  int                     pick;

  // Rotate the request vector so bit 0 is hart last_grant+1; the lowest set
  // bit of the rotated vector is then the distance to the winner.
  always_comb begin
    req_dbl = {req, req};
    req_rot = NUM_HARTS'(req_dbl >> (int'(last_grant) + 1));
    offset  = 0;
    for (int i = NUM_HARTS - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = i;
    end
    pick = int'(last_grant) + 1 + offset;
    if (pick >= NUM_HARTS) pick = pick - NUM_HARTS;
    valid     = |req;
    grant_idx = HART_CNT_WIDTH'(pick);
  end

endmodule

// File: rtl/mvu_job_dispatcher.sv
// MVU-side endpoint of the per-hart CSR/MVU interface. Collects per-hart job
// requests, grants them round-robin, snapshots the winner's configuration,
// launches the single MVU, waits for done (or timeout) and returns a
// one-cycle irq to the originating hart.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : mvu_job_dispatcher_if slave modport (CSR + MVU signals)
//   TIMEOUT_CYCLES : BUSY cycle limit before a forced error completion,
//                    0 disables the limit
module mvu_job_dispatcher
  import pito_pkg::*;
#(
  parameter int NUM_HARTS      = 8,
  parameter int HART_CNT_WIDTH = pito_pkg::HART_CNT_WIDTH,
  parameter int TIMEOUT_CYCLES = MVU_DISP_TIMEOUT
) (
  input logic                clk,
  input logic                rst_n,
  mvu_job_dispatcher_if.slave bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  mvu_disp_state_t           state;
  logic [NUM_HARTS-1:0]      pending;
  logic [NUM_HARTS-1:0]      pending_next;
  logic [NUM_HARTS-1:0]      clear_mask;
  logic [NUM_HARTS-1:0]      irq_onehot;
  logic [HART_CNT_WIDTH-1:0] last_grant;
  logic [CNT_W-1:0]          cnt;
  logic                      timeout_hit;
  logic                      arb_valid;
  logic [HART_CNT_WIDTH-1:0] arb_idx;
  logic [31:0] sel_w, sel_i, sel_o, sel_p, sel_c, sel_q;

  mvu_rr_arbiter #(
    .NUM_HARTS      (NUM_HARTS),
    .HART_CNT_WIDTH (HART_CNT_WIDTH)
  ) u_arb (
    .req        (pending),
    .last_grant (last_grant),
    .valid      (arb_valid),
    .grant_idx  (arb_idx)
  );

  // A new start for a bit being granted this edge must survive, so the set
  // is OR-ed in after the clear.
  always_comb begin
    clear_mask = '0;
    if (state == IDLE && arb_valid) clear_mask[arb_idx] = 1'b1;
    pending_next = (pending & ~clear_mask) | bus.mvu_start;
  end

  // Config mux for the current arbitration winner.
  always_comb begin
    sel_w = '0;
    sel_i = '0;
    sel_o = '0;
    sel_p = '0;
    sel_c = '0;
    sel_q = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (arb_idx == HART_CNT_WIDTH'(h)) begin
        sel_w = bus.csr_mvu_wbaseaddr[h*32 +: 32];
        sel_i = bus.csr_mvu_ibaseaddr[h*32 +: 32];
        sel_o = bus.csr_mvu_obaseaddr[h*32 +: 32];
        sel_p = bus.csr_mvu_precision[h*32 +: 32];
        sel_c = bus.csr_mvu_command[h*32 +: 32];
        sel_q = bus.csr_mvu_quant[h*32 +: 32];
      end
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign irq_onehot  = {{(NUM_HARTS-1){1'b0}}, 1'b1} << bus.active_hart_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      pending             <= '0;
      last_grant          <= HART_CNT_WIDTH'(NUM_HARTS - 1);
      cnt                 <= '0;
      bus.mvu_irq         <= '0;
      bus.mvu_start_o     <= 1'b0;
      bus.mvu_busy_o      <= 1'b0;
      bus.active_hart_o   <= '0;
      bus.mvu_err_o       <= 1'b0;
      bus.mvu_wbaseaddr_o <= '0;
      bus.mvu_ibaseaddr_o <= '0;
      bus.mvu_obaseaddr_o <= '0;
      bus.mvu_precision_o <= '0;
      bus.mvu_command_o   <= '0;
      bus.mvu_quant_o     <= '0;
    end else begin
      pending         <= pending_next;
      // Launch, irq and err are single-cycle pulses.
      bus.mvu_start_o <= 1'b0;
      bus.mvu_irq     <= '0;
      bus.mvu_err_o   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arb_valid) begin
            last_grant          <= arb_idx;
            bus.active_hart_o   <= arb_idx;
            bus.mvu_wbaseaddr_o <= sel_w;
            bus.mvu_ibaseaddr_o <= sel_i;
            bus.mvu_obaseaddr_o <= sel_o;
            bus.mvu_precision_o <= sel_p;
            bus.mvu_command_o   <= sel_c;
            bus.mvu_quant_o     <= sel_q;
            bus.mvu_start_o     <= 1'b1;
            bus.mvu_busy_o      <= 1'b1;
            state               <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt   <= '0;
          state <= BUSY;
        end
        BUSY: begin
          // Done takes precedence over a timeout in the same cycle.
          if (bus.mvu_done_i) begin
            bus.mvu_irq <= irq_onehot;
            state       <= IRQ;
          end else if (timeout_hit) begin
            bus.mvu_irq   <= irq_onehot;
            bus.mvu_err_o <= 1'b1;
            state         <= IRQ;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        IRQ: begin
          bus.mvu_busy_o <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
